// File: rtl/sync_fifo_rd_stream.sv
// Read-side streamer for a synchronous FIFO: issues reads and holds up to two words in a
// skid buffer. Delivers them over a valid/ready handshake and supports a flush that drains the FIFO.
module sync_fifo_rd_stream #(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_rden,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  flush_busy,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

  state_e                r_state, w_state_next;
  logic [FIFO_WIDTH-1:0] r_buf0, r_buf1, w_buf0_next, w_buf1_next;
  logic [1:0]            r_count, w_count_next, w_cnt_popped;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_xfer;
  logic                  w_pop;
  logic [2:0]            w_occ;

  assign m_valid    = (r_count != 2'd0) && (r_state != StFlush);
  assign m_data     = r_buf0;
  assign flush_busy = (r_state == StFlush);
  assign xfer_count = r_xfer;
  assign w_pop      = m_valid & m_ready;

  // Occupancy after this cycle's pop, counting the word still on its way from the FIFO.
  assign w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_comb begin
    fifo_rden = 1'b0;
    case (r_state)
      StStream: fifo_rden = enable && !fifo_empty && (w_occ < 3'd2);
      StFlush:  fifo_rden = !fifo_empty;
      default:  fifo_rden = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = StFlush;
    end else begin
      case (r_state)
        StIdle: begin
          if (enable) w_state_next = StStream;
        end
        StStream: begin
          if (!enable && (r_count == 2'd0) && !r_inflight) w_state_next = StIdle;
        end
        StFlush: begin
          if (fifo_empty && !r_inflight) w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Two-entry shift buffer: entry 0 is always the oldest word.
  always_comb begin
    w_buf0_next  = r_buf0;
    w_buf1_next  = r_buf1;
    w_cnt_popped = r_count - {1'b0, w_pop};
    w_count_next = w_cnt_popped;
    if (w_pop) w_buf0_next = r_buf1;
    if (flush || (r_state == StFlush)) begin
      // Anything buffered or arriving now belongs to the discarded stream.
      w_count_next = 2'd0;
    end else if (r_inflight) begin
      if (w_cnt_popped == 2'd0) begin
        w_buf0_next = fifo_rddata;
      end else begin
        w_buf1_next = fifo_rddata;
      end
      w_count_next = w_cnt_popped + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_xfer     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_buf0     <= w_buf0_next;
      r_buf1     <= w_buf1_next;
      r_count    <= w_count_next;
      r_inflight <= fifo_rden;
      if (w_pop) r_xfer <= r_xfer + 1'b1;
    end
  end

  a_no_read_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(fifo_rden && fifo_empty));
  a_count_bounded: assert property (@(posedge clk) disable iff (rst) r_count <= 2'd2);
  a_hold_under_backpressure: assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready && !flush) |=> (m_valid && $stable(m_data)));

endmodule

// File: doc/sync_fifo_rd_stream.md
SYNC_FIFO_RD_STREAM -- requirements
Module: sync_fifo_rd_stream

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the delivered-word counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  permits new FIFO reads when high.
REQ-006 SHALL have port flush  input  1  single-cycle request to discard buffered and FIFO contents.
REQ-007 SHALL have port fifo_empty  input  1  empty flag from the sync FIFO.
REQ-008 SHALL have port fifo_rddata  input  FIFO_WIDTH  FIFO read data, valid the cycle after fifo_rden.
REQ-009 SHALL have port fifo_rden  output  1  FIFO read strobe.
REQ-010 SHALL have port m_valid  output  1  output word available.
REQ-011 SHALL have port m_data  output  FIFO_WIDTH  output word.
REQ-012 SHALL have port m_ready  input  1  downstream accepts the word.
REQ-013 SHALL have port flush_busy  output  1  high while in FLUSH state.
REQ-014 SHALL have port xfer_count  output  CNT_WIDTH  count of words accepted downstream.

Function
REQ-015 SHALL implement states IDLE, STREAM, FLUSH; reset state IDLE.
REQ-016 IDLE->STREAM when enable=1 and flush=0; STREAM->IDLE when enable=0, buffer empty and no read in flight.
REQ-017 flush=1 in any state SHALL enter FLUSH next cycle; flush takes priority over enable.
REQ-018 FLUSH->IDLE when fifo_empty=1 and no read in flight; flush_busy=1 exactly while in FLUSH.
REQ-019 SHALL hold a 2-entry output buffer (FIFO order); m_valid=1 whenever buffer count>0 and state!=FLUSH; m_data = oldest entry.
REQ-020 Transfer occurs in a cycle with m_valid=1 and m_ready=1; oldest entry popped at that edge.
REQ-021 In STREAM, fifo_rden=1 iff enable=1, fifo_empty=0, and (buf_count + rd_inflight - pop) < 2, where rd_inflight = fifo_rden of previous cycle and pop = transfer this cycle.
REQ-022 fifo_rden SHALL never be asserted when fifo_empty=1 (any state).
REQ-023 fifo_rdata SHALL be captured into the buffer at the end of the cycle after fifo_rden; m_valid for that word SHALL first be high in cycle N+2 for rden in cycle N.
REQ-024 Steady-state throughput SHALL be one word per cycle when FIFO non-empty and m_ready held 1.
REQ-025 m_valid/m_data SHALL remain stable while m_valid=1 and m_ready=0; buffer never overflows.
REQ-026 enable deasserted mid-stream: no new reads; in-flight word still captured; buffered words still delivered.
REQ-027 In FLUSH: buffer cleared on entry, m_valid=0, fifo_rden=1 every cycle fifo_empty=0, returned data discarded, xfer_count unchanged.
REQ-028 xfer_count SHALL increment by 1 per transfer, wrap modulo 2^CNT_WIDTH.
REQ-029 Read in flight at a flush edge SHALL be discarded, not captured.

Reset
REQ-030 On rst=1 at a clock edge: state IDLE, buffer empty, rd_inflight=0, fifo_rden=0, m_valid=0, m_data=0, flush_busy=0, xfer_count=0.
REQ-031 rst SHALL override flush and enable; a read in flight at reset SHALL be discarded.

Verification
REQ-032 Latency: FIFO holds 0xA5, enable=1, m_ready=1 -> fifo_rden cycle N, m_valid=1 m_data=0xA5 cycle N+2, xfer_count=1 after.
REQ-033 Throughput: 8 words 0x01..0x08, m_ready=1 -> 8 consecutive m_valid cycles in order, xfer_count=8.
REQ-034 Backpressure: m_ready=0 with FIFO non-empty -> exactly 2 reads issued, m_data held at first word, fifo_rden=0 thereafter; release -> remaining words in order, none lost or duplicated.
REQ-035 Flush: 2 words buffered plus 3 in FIFO, pulse flush -> m_valid=0, fifo_rden 3 cycles, flush_busy high until fifo_empty and no in-flight, xfer_count unchanged, state IDLE.
REQ-036 Empty guard and wrap: fifo_empty=1 throughout -> fifo_rden never 1; CNT_WIDTH=4 with 17 transfers -> xfer_count=1.
REQ-037 Mid-stream reset: rst=1 with 2 buffered words and read in flight -> next cycle all outputs at reset values, in-flight word not presented.
